// File: rtl/aurora_top.sv
// Aurora-style 64B/66B lane transmitter: channel-init FSM plus beat striping across up to MAX_LINKS lanes.
// Latency: encoded_data is registered, one cycle after inputs; no backpressure, so a beat offered during a separator cycle is dropped.
package aurora_pkg;
    localparam int MAX_LINKS         = 4;
    localparam int MAX_LINKS_SIZE    = 2;
    localparam int AXI_DATA_SIZE     = 64;
    localparam int ENCODED_DATA_SIZE = 66;
endpackage

module aurora_top
    import aurora_pkg::*;
(
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               single_lane,
    input  logic [MAX_LINKS_SIZE-1:0]                          lane_select,
    input  logic                                               axi_valid,
    input  logic                                               axi_last,
    input  logic [AXI_DATA_SIZE-1:0]                           axi_data,
    input  logic                                               simplex_aligned,
    input  logic                                               simplex_bonded,
    input  logic                                               simplex_verified,
    input  logic                                               simplex_reset,
    output logic [MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0]        encoded_data
);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_ALIGN,
        ST_BOND,
        ST_VERIFY,
        ST_READY
    } state_t;

    localparam logic [ENCODED_DATA_SIZE-1:0] BLK_IDLE   = {2'b10, 64'h7800_0000_0000_0000};
    localparam logic [ENCODED_DATA_SIZE-1:0] BLK_IDLE_NR = {2'b10, 64'h7820_0000_0000_0000};
    localparam logic [ENCODED_DATA_SIZE-1:0] BLK_IDLE_CB = {2'b10, 64'h7880_0000_0000_0000};
    localparam logic [ENCODED_DATA_SIZE-1:0] BLK_VERIFY = {2'b10, 64'hE800_0000_0000_0000};
    localparam logic [ENCODED_DATA_SIZE-1:0] BLK_SEP    = {2'b10, 64'h1E00_0000_0000_0000};

    state_t                                      state_q, state_d;
    logic [MAX_LINKS_SIZE-1:0]                   rr_q, rr_d;
    logic                                        sep_pend_q, sep_pend_d;
    logic [MAX_LINKS_SIZE-1:0]                   sep_lane_q, sep_lane_d;
    logic [MAX_LINKS-1:0][ENCODED_DATA_SIZE-1:0] enc_q, enc_d;

    logic                                        channel_init_finished;
    logic                                        beat_ok;
    logic                                        sep_fire;
    logic [MAX_LINKS_SIZE-1:0]                   tgt_lane;
    logic [ENCODED_DATA_SIZE-1:0]                state_blk;
    logic [ENCODED_DATA_SIZE-1:0]                lane_blk;

    assign channel_init_finished = (state_q == ST_READY);
    assign encoded_data          = enc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_ALIGN;
            ST_ALIGN:  if (simplex_aligned) state_d = single_lane ? ST_VERIFY : ST_BOND;
            ST_BOND:   if (simplex_bonded) state_d = ST_VERIFY;
            ST_VERIFY: if (simplex_verified) state_d = ST_READY;
            ST_READY:  state_d = ST_READY;
            default:   state_d = ST_RESET;
        endcase
        if (simplex_reset) begin
            state_d = ST_RESET;
        end
    end

    // A beat is only taken in a READY cycle that is neither being torn down nor owed to a separator.
    always_comb begin
        beat_ok    = (state_q == ST_READY) && !simplex_reset && axi_valid && !sep_pend_q;
        sep_fire   = sep_pend_q && !simplex_reset;
        tgt_lane   = single_lane ? lane_select : rr_q;
        sep_pend_d = beat_ok && axi_last;
        sep_lane_d = beat_ok ? tgt_lane : sep_lane_q;

        rr_d = rr_q;
        if (state_q != ST_READY) begin
            rr_d = '0;
        end else if (beat_ok && !single_lane) begin
            rr_d = rr_q + MAX_LINKS_SIZE'(1);
        end

        case (state_d)
            ST_ALIGN:  state_blk = BLK_IDLE_NR;
            ST_BOND:   state_blk = BLK_IDLE_CB;
            ST_VERIFY: state_blk = BLK_VERIFY;
            ST_READY:  state_blk = BLK_IDLE;
            default:   state_blk = '0;
        endcase

        enc_d    = '0;
        lane_blk = '0;
        for (int i = 0; i < MAX_LINKS; i++) begin
            lane_blk = state_blk;
            if (single_lane && (lane_select != MAX_LINKS_SIZE'(i))) begin
                lane_blk = '0;
            end
            if (sep_fire && (sep_lane_q == MAX_LINKS_SIZE'(i))) begin
                lane_blk = BLK_SEP;
            end
            if (beat_ok && (tgt_lane == MAX_LINKS_SIZE'(i))) begin
                lane_blk = {2'b01, axi_data};
            end
            enc_d[i] = lane_blk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            rr_q       <= '0;
            sep_pend_q <= 1'b0;
            sep_lane_q <= '0;
            enc_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            sep_pend_q <= sep_pend_d;
            sep_lane_q <= sep_lane_d;
            enc_q      <= enc_d;
        end
    end

endmodule

// File: tb/tb_aurora_top.sv
// Directed vector bench for aurora_top: init FSM in both modes, framing, striping, and reset corners.
module tb_aurora_top;
    import aurora_pkg::*;

    typedef logic [3:0][65:0] lanes_t;

    typedef struct {
        string       name;
        logic        single;
        logic [1:0]  lsel;
        logic        valid;
        logic        last;
        logic [63:0] data;
        logic        al;
        logic        bo;
        logic        ve;
        logic        sr;
        lanes_t      exp;
        logic        cif;
    } vec_t;

    localparam logic [65:0] NR  = {2'b10, 64'h7820_0000_0000_0000};
    localparam logic [65:0] CB  = {2'b10, 64'h7880_0000_0000_0000};
    localparam logic [65:0] IDL = {2'b10, 64'h7800_0000_0000_0000};
    localparam logic [65:0] VER = {2'b10, 64'hE800_0000_0000_0000};
    localparam logic [65:0] SEP = {2'b10, 64'h1E00_0000_0000_0000};

    logic        clk;
    logic        rst_n;
    logic        single_lane;
    logic [1:0]  lane_select;
    logic        axi_valid;
    logic        axi_last;
    logic [63:0] axi_data;
    logic        simplex_aligned;
    logic        simplex_bonded;
    logic        simplex_verified;
    logic        simplex_reset;
    lanes_t      encoded_data;

    int checks;
    int errors;
    vec_t vecs [25];

    aurora_top dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .single_lane      (single_lane),
        .lane_select      (lane_select),
        .axi_valid        (axi_valid),
        .axi_last         (axi_last),
        .axi_data         (axi_data),
        .simplex_aligned  (simplex_aligned),
        .simplex_bonded   (simplex_bonded),
        .simplex_verified (simplex_verified),
        .simplex_reset    (simplex_reset),
        .encoded_data     (encoded_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] dat(input logic [63:0] d);
        return {2'b01, d};
    endfunction

    // Single-lane expectation: one lane carries b, the rest are zero.
    function automatic lanes_t sl(input int lane, input logic [65:0] b);
        lanes_t r;
        r = '0;
        r[lane] = b;
        return r;
    endfunction

    // Multi-lane expectation: every lane carries base, optionally one lane overridden.
    function automatic lanes_t ml(input logic [65:0] base, input int lane, input logic [65:0] b);
        lanes_t r;
        for (int i = 0; i < 4; i++) r[i] = base;
        if (lane >= 0) r[lane] = b;
        return r;
    endfunction

    function automatic vec_t mk(input string name, input logic single, input logic [1:0] lsel,
                                input logic valid, input logic last, input logic [63:0] data,
                                input logic al, input logic bo, input logic ve, input logic sr,
                                input lanes_t exp, input logic cif);
        vec_t v;
        v.name = name; v.single = single; v.lsel = lsel; v.valid = valid; v.last = last;
        v.data = data; v.al = al; v.bo = bo; v.ve = ve; v.sr = sr; v.exp = exp; v.cif = cif;
        return v;
    endfunction

    task automatic chk_lane(input string name, input int lane, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %h expected %h", name, lane, act, exp);
        end
    endtask

    task automatic chk_cif(input string name, input logic exp);
        checks++;
        if (dut.channel_init_finished !== exp) begin
            errors++;
            $display("FAIL %s cif: got %b expected %b", name, dut.channel_init_finished, exp);
        end
    endtask

    task automatic chk_all(input string name, input lanes_t exp, input logic cif);
        for (int i = 0; i < 4; i++) chk_lane(name, i, encoded_data[i], exp[i]);
        chk_cif(name, cif);
    endtask

    task automatic drive(input vec_t v);
        single_lane      = v.single;
        lane_select      = v.lsel;
        axi_valid        = v.valid;
        axi_last         = v.last;
        axi_data         = v.data;
        simplex_aligned  = v.al;
        simplex_bonded   = v.bo;
        simplex_verified = v.ve;
        simplex_reset    = v.sr;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        chk_all(v.name, v.exp, v.cif);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = mk("release_align",   1, 2, 0, 0, 64'h0,                  0, 0, 0, 0, sl(2, NR),  0);
        vecs[1]  = mk("align_no_data",   1, 2, 1, 1, 64'hDEAD,               0, 0, 0, 0, sl(2, NR),  0);
        vecs[2]  = mk("skip_bond",       1, 2, 0, 0, 64'h0,                  1, 0, 0, 0, sl(2, VER), 0);
        vecs[3]  = mk("hold_verify",     1, 2, 0, 0, 64'h0,                  0, 0, 0, 0, sl(2, VER), 0);
        vecs[4]  = mk("ready_idle",      1, 2, 0, 0, 64'h0,                  0, 0, 1, 0, sl(2, IDL), 1);
        vecs[5]  = mk("beat_last",       1, 2, 1, 1, 64'h0123456789ABCDEF,   0, 0, 0, 0, sl(2, dat(64'h0123456789ABCDEF)), 1);
        vecs[6]  = mk("sep_drop",        1, 2, 1, 0, 64'hAAAA,               0, 0, 0, 0, sl(2, SEP), 1);
        vecs[7]  = mk("after_sep_idle",  1, 2, 0, 0, 64'h0,                  0, 0, 0, 0, sl(2, IDL), 1);
        vecs[8]  = mk("beat_mid",        1, 2, 1, 0, 64'h5555,               0, 0, 0, 0, sl(2, dat(64'h5555)), 1);
        vecs[9]  = mk("lane_change",     1, 1, 1, 0, 64'h1111,               0, 0, 0, 0, sl(1, dat(64'h1111)), 1);
        vecs[10] = mk("sreset_single",   1, 2, 1, 0, 64'h2222,               0, 0, 0, 1, '0,         0);
        vecs[11] = mk("realign_single",  1, 2, 0, 0, 64'h0,                  0, 0, 0, 0, sl(2, NR),  0);
        vecs[12] = mk("multi_align",     0, 2, 0, 0, 64'h0,                  0, 0, 0, 0, ml(NR, -1, '0),  0);
        vecs[13] = mk("multi_bond",      0, 2, 0, 0, 64'h0,                  1, 0, 0, 0, ml(CB, -1, '0),  0);
        vecs[14] = mk("multi_verify",    0, 2, 0, 0, 64'h0,                  0, 1, 0, 0, ml(VER, -1, '0), 0);
        vecs[15] = mk("multi_ready",     0, 2, 0, 0, 64'h0,                  0, 0, 1, 0, ml(IDL, -1, '0), 1);
        vecs[16] = mk("rr_beat0",        0, 2, 1, 0, 64'hA0,                 0, 0, 0, 0, ml(IDL, 0, dat(64'hA0)), 1);
        vecs[17] = mk("rr_beat1",        0, 2, 1, 0, 64'hA1,                 0, 0, 0, 0, ml(IDL, 1, dat(64'hA1)), 1);
        vecs[18] = mk("rr_beat2",        0, 2, 1, 0, 64'hA2,                 0, 0, 0, 0, ml(IDL, 2, dat(64'hA2)), 1);
        vecs[19] = mk("rr_beat3",        0, 2, 1, 0, 64'hA3,                 0, 0, 0, 0, ml(IDL, 3, dat(64'hA3)), 1);
        vecs[20] = mk("rr_wrap_last",    0, 2, 1, 1, 64'hA4,                 0, 0, 0, 0, ml(IDL, 0, dat(64'hA4)), 1);
        vecs[21] = mk("multi_sep_drop",  0, 2, 1, 0, 64'hB0,                 0, 0, 0, 0, ml(IDL, 0, SEP), 1);
        vecs[22] = mk("rr_after_sep",    0, 2, 1, 0, 64'hB1,                 0, 0, 0, 0, ml(IDL, 1, dat(64'hB1)), 1);
        vecs[23] = mk("sreset_multi",    0, 2, 1, 1, 64'hB2,                 0, 0, 0, 1, '0,         0);
        vecs[24] = mk("reset_no_data",   0, 2, 1, 0, 64'hB3,                 0, 0, 0, 0, ml(NR, -1, '0),  0);

        rst_n = 1'b0;
        drive(mk("idle", 1, 2, 0, 0, 64'h0, 0, 0, 0, 0, '0, 0));
        repeat (3) @(posedge clk);
        #1;
        chk_all("in_reset", '0, 0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 25; k++) step(vecs[k]);

        // Async reset with a separator owed: the separator must not survive reset.
        step(mk("hs_verify", 1, 0, 0, 0, 64'h0, 1, 0, 0, 0, sl(0, VER), 0));
        step(mk("hs_ready",  1, 0, 0, 0, 64'h0, 0, 0, 1, 0, sl(0, IDL), 1));
        step(mk("hs_last",   1, 0, 1, 1, 64'hC0FFEE, 0, 0, 0, 0, sl(0, dat(64'hC0FFEE)), 1));
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk("idle", 1, 0, 0, 0, 64'h0, 0, 0, 0, 0, '0, 0));
        #1;
        chk_all("hs_async_rst", '0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("hs_no_sep", sl(0, NR), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
